// File: rtl/fresh_mask_gen.sv
// fresh_mask_gen: fresh randomness for the masked GF(4) multiplier pair of the
// two-share S-box datapath. A seeded 32-bit LFSR (x^32+x^22+x^2+x+1) advances
// 8 steps per update. Each generated byte supplies one 4-bit mask word per
// S-box instance: low nibble to S-box A, high nibble to S-box B.
//
// Optional repetition health test: compile with `define FRESH_MASK_HEALTH_EN.
// Without it, rng_alarm is tied low and no health logic is built.
//
// Handshakes (valid/ready):
//   - A seed transfers on a rising clk edge where seed_valid & seed_ready.
//     seed_ready is high only in IDLE or RUN and never while rst_n is low.
//   - A mask word transfers on a rising clk edge where rnd_valid & rnd_req.
//     While rnd_valid is high and rnd_req is low, the words are held stable.
//     rnd_req only affects registered state; it has no combinational path to
//     any output.
//
// The FSM state is the internal signal `state` (ST_IDLE, ST_WARMUP, ST_RUN),
// readable hierarchically by checkers.

module fresh_mask_gen #(
  parameter int unsigned WARMUP_CYCLES    = 8,
  parameter int unsigned RESEED_INTERVAL  = 1024,
  parameter int unsigned HEALTH_REP_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] seed,
  input  logic        seed_valid,
  output logic        seed_ready,
  output logic [3:0]  ra3ra2ra1ra0,
  output logic [3:0]  rb3rb2rb1rb0,
  output logic        rnd_valid,
  input  logic        rnd_req,
  output logic        reseed_req,
  output logic        rng_alarm
);

  // Catch out-of-range parameters at elaboration.
  if (RESEED_INTERVAL < 1 || RESEED_INTERVAL > 65535 ||
      HEALTH_REP_LIMIT < 1 || WARMUP_CYCLES > 65536) begin : g_bad_params
    $error("fresh_mask_gen: parameter out of range");
  end

  // Index of the final warm-up update. This value is only used when
  // WARMUP_CYCLES is non-zero; a zero setting skips the WARMUP state.
  localparam logic [15:0] WARM_LAST =
    (WARMUP_CYCLES > 0) ? 16'(WARMUP_CYCLES - 1) : 16'd0;
  localparam bit          NO_WARMUP    = (WARMUP_CYCLES == 0);
  localparam logic [15:0] RESEED_LIMIT = 16'(RESEED_INTERVAL);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] lfsr;
  logic [31:0] lfsr_next;
  logic [31:0] seed_eff;
  logic        seed_fire;
  logic        consume;
  logic        gen;
  logic        trip;
  logic [15:0] warm_cnt;
  logic [15:0] word_base;
  logic [15:0] word_cnt;
  logic [15:0] word_cnt_nxt;

  // One update: eight single-bit LFSR steps. Afterwards, the new bits sit in [7:0].
  function automatic logic [31:0] lfsr_update(input logic [31:0] s_in);
    logic [31:0] s;
    s = s_in;
    for (int i = 0; i < 8; i++) begin
      s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    end
    return s;
  endfunction

  // Handshake decode and next-update value.
  always_comb begin
    seed_ready = rst_n && (state == ST_IDLE || state == ST_RUN);
    seed_fire  = seed_valid && seed_ready;
    consume    = rnd_valid && rnd_req;
    // The all-zero state would lock up the LFSR, so a zero seed becomes 1.
    seed_eff   = (seed == 32'h0) ? 32'h0000_0001 : seed;
    lfsr_next  = lfsr_update(lfsr);
    // A seed load wins over generation in the same cycle.
    gen        = (state == ST_RUN) && (!rnd_valid || rnd_req) && !seed_fire;
  end

  // FSM next state.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (seed_fire) state_nxt = NO_WARMUP ? ST_RUN : ST_WARMUP;
      end
      ST_WARMUP: begin
        if (warm_cnt == WARM_LAST) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (seed_fire)  state_nxt = NO_WARMUP ? ST_RUN : ST_WARMUP;
        else if (trip)  state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Warm-up update counter, restarted on every seed load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  warm_cnt <= 16'd0;
    else if (seed_fire)          warm_cnt <= 16'd0;
    else if (state == ST_WARMUP) warm_cnt <= warm_cnt + 16'd1;
  end

  // LFSR: a seed load replaces the state; warm-up and generation advance it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          lfsr <= 32'h0;
    else if (seed_fire)                  lfsr <= seed_eff;
    else if (state == ST_WARMUP || gen)  lfsr <= lfsr_next;
  end

  // Registered mask words and valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra3ra2ra1ra0 <= 4'h0;
      rb3rb2rb1rb0 <= 4'h0;
      rnd_valid    <= 1'b0;
    end else if (seed_fire) begin
      rnd_valid <= 1'b0;
    end else if (gen) begin
      ra3ra2ra1ra0 <= lfsr_next[3:0];
      rb3rb2rb1rb0 <= lfsr_next[7:4];
      rnd_valid    <= !trip;
    end
  end

  // Accepted-word count. A seed load restarts the count, but a word taken in
  // the same cycle as the load is still counted against the new seed.
  always_comb begin
    word_base    = seed_fire ? 16'd0 : word_cnt;
    word_cnt_nxt = word_base;
    if (consume && word_base < RESEED_LIMIT) word_cnt_nxt = word_base + 16'd1;
  end

  // Counter and reseed request registers (saturating at RESEED_LIMIT).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt   <= 16'd0;
      reseed_req <= 1'b0;
    end else begin
      word_cnt   <= word_cnt_nxt;
      reseed_req <= (word_cnt_nxt >= RESEED_LIMIT);
    end
  end

`ifdef FRESH_MASK_HEALTH_EN
  localparam logic [15:0] REP_LIMIT = 16'(HEALTH_REP_LIMIT);

  logic [7:0]  last_word;
  logic [15:0] rep_cnt;
  logic [15:0] rep_nxt;
  logic        alarm_q;

  // Run length of identical generated words; zero means no word since seed.
  always_comb begin
    rep_nxt = rep_cnt;
    trip    = 1'b0;
    if (gen) begin
      if (rep_cnt != 16'd0 && lfsr_next[7:0] == last_word) begin
        if (rep_cnt != 16'hFFFF) rep_nxt = rep_cnt + 16'd1;
      end else begin
        rep_nxt = 16'd1;
      end
      trip = (rep_nxt >= REP_LIMIT);
    end
  end

  // Health state: last word, run length and the sticky alarm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_word <= 8'h0;
      rep_cnt   <= 16'd0;
      alarm_q   <= 1'b0;
    end else if (seed_fire) begin
      last_word <= 8'h0;
      rep_cnt   <= 16'd0;
      alarm_q   <= 1'b0;
    end else if (gen) begin
      last_word <= lfsr_next[7:0];
      rep_cnt   <= rep_nxt;
      if (trip) alarm_q <= 1'b1;
    end
  end

  assign rng_alarm = alarm_q;
`else
  assign trip      = 1'b0;
  assign rng_alarm = 1'b0;
`endif

endmodule

// File: tb/tb_fresh_mask_gen.sv
// tb_fresh_mask_gen: directed checks of fresh_mask_gen.
// The u_dut_a instance uses no warm-up and a reseed interval of 4.
// The u_dut_b instance uses 8 warm-up updates and the default interval.
// Inputs change on the falling edge. Outputs are sampled on the falling edge,
// half a period after the active edge.

module tb_fresh_mask_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] seed_a, seed_b;
  logic        seed_valid_a, seed_valid_b;
  logic        rnd_req_a, rnd_req_b;
  logic        seed_ready_a, seed_ready_b;
  logic [3:0]  ra_a, rb_a, ra_b, rb_b;
  logic        rnd_valid_a, rnd_valid_b;
  logic        reseed_req_a, reseed_req_b;
  logic        rng_alarm_a, rng_alarm_b;

  fresh_mask_gen #(.WARMUP_CYCLES(0), .RESEED_INTERVAL(4), .HEALTH_REP_LIMIT(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .seed(seed_a), .seed_valid(seed_valid_a),
    .seed_ready(seed_ready_a), .ra3ra2ra1ra0(ra_a), .rb3rb2rb1rb0(rb_a),
    .rnd_valid(rnd_valid_a), .rnd_req(rnd_req_a), .reseed_req(reseed_req_a),
    .rng_alarm(rng_alarm_a)
  );

  fresh_mask_gen #(.WARMUP_CYCLES(8), .RESEED_INTERVAL(1024), .HEALTH_REP_LIMIT(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .seed(seed_b), .seed_valid(seed_valid_b),
    .seed_ready(seed_ready_b), .ra3ra2ra1ra0(ra_b), .rb3rb2rb1rb0(rb_b),
    .rnd_valid(rnd_valid_b), .rnd_req(rnd_req_b), .reseed_req(reseed_req_b),
    .rng_alarm(rng_alarm_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fails  = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference LFSR update: 8 steps of x^32+x^22+x^2+x+1.
  function automatic logic [31:0] ref_update(input logic [31:0] s_in);
    logic [31:0] s;
    s = s_in;
    for (int i = 0; i < 8; i++) s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_a_word(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    check_eq({tag, "_valid"}, {31'b0, rnd_valid_a}, 32'd1);
    check_eq({tag, "_word"}, {24'b0, rb_a, ra_a}, {24'b0, e});
  endtask

  // Safety net in case stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] m;
    logic [31:0] mb;
    logic [7:0]  held;
    int          acc;

    rst_n = 1'b0;
    seed_a = '0; seed_b = '0;
    seed_valid_a = 1'b0; seed_valid_b = 1'b0;
    rnd_req_a = 1'b0; rnd_req_b = 1'b0;

    // Reset values
    repeat (2) tick();
    check_eq("rst_valid",  {31'b0, rnd_valid_a}, 32'd0);
    check_eq("rst_word",   {24'b0, rb_a, ra_a}, 32'd0);
    check_eq("rst_reseed", {31'b0, reseed_req_a}, 32'd0);
    check_eq("rst_sready", {31'b0, seed_ready_a}, 32'd0);
`ifndef FRESH_MASK_HEALTH_EN
    check_eq("rst_alarm",  {31'b0, rng_alarm_a}, 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    check_eq("idle_sready", {31'b0, seed_ready_a}, 32'd1);
    check_eq("idle_state",  32'(u_dut_a.state), 32'd0);

    // First word, W=0, seed 1: word 8'hB6 (ra=6, rb=B) two cycles after handshake
    tick();
    seed_a = 32'h0000_0001; seed_valid_a = 1'b1;
    tick();
    seed_valid_a = 1'b0;
    check_eq("a_lat1_valid", {31'b0, rnd_valid_a}, 32'd0);
    tick();
    check_eq("a_first_valid", {31'b0, rnd_valid_a}, 32'd1);
    check_eq("a_first_ra", {28'b0, ra_a}, 32'h6);
    check_eq("a_first_rb", {28'b0, rb_a}, 32'hB);

    // Streaming with rnd_req held high; reseed_req after the 4th accepted word
    m = ref_update(32'h1);
    acc = 0;
    rnd_req_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      m = ref_update(m);
      exp_q.push_back(m[7:0]);
      tick();
      acc++;
      check_a_word("a_stream");
      check_eq("a_reseed", {31'b0, reseed_req_a}, (acc >= 4) ? 32'd1 : 32'd0);
    end

    // Reseed with zero: clears reseed_req, drops rnd_valid, restarts as seed 1
    rnd_req_a = 1'b0;
    seed_a = 32'h0; seed_valid_a = 1'b1;
    tick();
    seed_valid_a = 1'b0;
    check_eq("a_rs_valid",  {31'b0, rnd_valid_a}, 32'd0);
    check_eq("a_rs_reseed", {31'b0, reseed_req_a}, 32'd0);
    tick();
    exp_q.push_back(8'hB6);
    check_a_word("a_zero_first");
    m = ref_update(32'h1);
    rnd_req_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m = ref_update(m);
      exp_q.push_back(m[7:0]);
      tick();
      check_a_word("a_zero_seq");
      check_eq("a_zero_reseed", {31'b0, reseed_req_a}, 32'd0);
    end
    rnd_req_a = 1'b0;

    // W=8: warm-up, first word at T+10 equals the 9th update
    seed_b = 32'h1234_5678; seed_valid_b = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      seed_valid_b = 1'b0;
      check_eq("b_warm_valid",  {31'b0, rnd_valid_b}, 32'd0);
      check_eq("b_warm_sready", {31'b0, seed_ready_b}, (k == 9) ? 32'd1 : 32'd0);
    end
    tick();
    mb = 32'h1234_5678;
    for (int k = 0; k < 9; k++) mb = ref_update(mb);
    check_eq("b_first_valid", {31'b0, rnd_valid_b}, 32'd1);
    check_eq("b_first_word",  {24'b0, rb_b, ra_b}, {24'b0, mb[7:0]});

    // Stall: outputs hold for 5 cycles while rnd_req is low
    held = mb[7:0];
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("b_stall_valid", {31'b0, rnd_valid_b}, 32'd1);
      check_eq("b_stall_word",  {24'b0, rb_b, ra_b}, {24'b0, held});
    end
    rnd_req_b = 1'b1;
    tick();
    rnd_req_b = 1'b0;
    mb = ref_update(mb);
    check_eq("b_next_word", {24'b0, rb_b, ra_b}, {24'b0, mb[7:0]});
    tick();
    check_eq("b_next_hold", {24'b0, rb_b, ra_b}, {24'b0, mb[7:0]});

    // Reset mid-RUN: outputs clear immediately, without waiting for a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid_a", {31'b0, rnd_valid_a}, 32'd0);
    check_eq("mid_rst_valid_b", {31'b0, rnd_valid_b}, 32'd0);
    check_eq("mid_rst_word_b",  {24'b0, rb_b, ra_b}, 32'd0);
    check_eq("mid_rst_sready",  {31'b0, seed_ready_a}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_sready", {31'b0, seed_ready_b}, 32'd1);
    check_eq("post_rst_state",  32'(u_dut_b.state), 32'd0);
    tick();
    tick();
    check_eq("post_rst_idle_valid", {31'b0, rnd_valid_a}, 32'd0);
`ifndef FRESH_MASK_HEALTH_EN
    check_eq("end_alarm", {31'b0, rng_alarm_b}, 32'd0);
`endif

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
